// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// pll_lock_supervisor : PLL reset sequencer, lock filter and domain reset gate
// Revision: 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
   parameter int NUM_PLL        = 1,
   parameter int PLL_RST_CYCLES = 4,
   parameter int LOCK_FILTER    = 8,
   parameter int HOLD_CYCLES    = 16,
   parameter int LOCK_TIMEOUT   = 64,
   parameter int MAX_RETRIES    = 2,
   localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic               clkin,
   input  logic               resetn,
   input  logic [NUM_PLL-1:0] pll_lock,
   output logic [NUM_PLL-1:0] pll_reset,
   output logic               rst_out_n,
   output logic               ready,
   output logic               fault,
   output logic               lock_lost,
   output logic [NUM_PLL-1:0] lost_mask,
   output logic [RETRY_W-1:0] retry_count
);

   localparam int CNT_MAX01 = (PLL_RST_CYCLES > HOLD_CYCLES) ? PLL_RST_CYCLES : HOLD_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX01 > LOCK_TIMEOUT) ? CNT_MAX01 : LOCK_TIMEOUT;
   localparam int CNT_W     = $clog2(CNT_MAX);
   localparam int FILT_W    = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;

   localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [FILT_W-1:0]  FILT_LAST    = FILT_W'(LOCK_FILTER - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_HOLD      = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [FILT_W-1:0]    fcnt, fcnt_n;
   logic [RETRY_W-1:0]   retry_n;
   logic [NUM_PLL-1:0]   sync_meta, sync_lock;
   logic [NUM_PLL-1:0]   lost_bits_n;
   logic                 all_lock, lost_n, fail_attempt, armed;

   assign all_lock = &sync_lock;

   // The first cycle after reset release is the entry cycle of the initial
   // PLL reset pulse, so the pulse counter only starts once armed is set.
   always_ff @(posedge clkin) begin
      if (!resetn) begin
         state       <= ST_PLL_RST;
         cnt         <= '0;
         fcnt        <= '0;
         retry_count <= '0;
         armed       <= 1'b0;
         sync_meta   <= '0;
         sync_lock   <= '0;
         pll_reset   <= {NUM_PLL{1'b1}};
         rst_out_n   <= 1'b0;
         ready       <= 1'b0;
         fault       <= 1'b0;
         lock_lost   <= 1'b0;
         lost_mask   <= '0;
      end else begin
         sync_meta   <= pll_lock;
         sync_lock   <= sync_meta;
         armed       <= 1'b1;
         state       <= state_n;
         cnt         <= cnt_n;
         fcnt        <= fcnt_n;
         retry_count <= retry_n;
         pll_reset   <= {NUM_PLL{(state_n == ST_PLL_RST) || (state_n == ST_FAULT)}};
         rst_out_n   <= (state_n == ST_RUN);
         ready       <= (state_n == ST_RUN);
         fault       <= (state_n == ST_FAULT);
         lock_lost   <= lost_n;
         lost_mask   <= lost_mask | lost_bits_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      fcnt_n       = fcnt;
      retry_n      = retry_count;
      lost_n       = 1'b0;
      lost_bits_n  = '0;
      fail_attempt = 1'b0;
      case (state)
         ST_PLL_RST: begin
            if (cnt == RST_LAST) begin
               state_n = ST_WAIT_LOCK;
               cnt_n   = '0;
               fcnt_n  = '0;
            end else if (armed) begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_WAIT_LOCK: begin
            fcnt_n = all_lock ? fcnt + 1'b1 : '0;
            cnt_n  = cnt + 1'b1;
            // Lock acceptance takes priority over a coincident timeout.
            if (all_lock && (fcnt == FILT_LAST)) begin
               state_n = ST_HOLD;
               cnt_n   = '0;
               fcnt_n  = '0;
            end else if (cnt == TIMEOUT_LAST) begin
               fail_attempt = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!all_lock) begin
               fail_attempt = 1'b1;
            end else if (cnt == HOLD_LAST) begin
               state_n = ST_RUN;
               cnt_n   = '0;
               retry_n = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ST_RUN: begin
            retry_n = '0;
            if (!all_lock) begin
               state_n     = ST_PLL_RST;
               cnt_n       = '0;
               lost_n      = 1'b1;
               lost_bits_n = ~sync_lock;
            end
         end
         ST_FAULT: begin
            state_n = ST_FAULT;
         end
         default: begin
            state_n = ST_PLL_RST;
            cnt_n   = '0;
            fcnt_n  = '0;
         end
      endcase

      if (fail_attempt) begin
         cnt_n  = '0;
         fcnt_n = '0;
         if (retry_count == RETRY_LIMIT) begin
            state_n = ST_FAULT;
         end else begin
            state_n = ST_PLL_RST;
            retry_n = retry_count + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// tb_pll_lock_supervisor : scoreboard bench with a timeline-based lock model
// Revision: 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

   localparam int NP  = 2;
   localparam int PRC = 4;
   localparam int LF  = 8;
   localparam int HC  = 16;
   localparam int LT  = 64;
   localparam int MR  = 2;

   localparam int PH_RST   = 0;
   localparam int PH_WAIT  = 1;
   localparam int PH_HOLD  = 2;
   localparam int PH_RUN   = 3;
   localparam int PH_FAULT = 4;

   typedef struct packed {
      logic [NP-1:0] pll_reset;
      logic          rst_out_n;
      logic          ready;
      logic          fault;
      logic          lock_lost;
      logic [NP-1:0] lost_mask;
      logic [1:0]    retry;
   } outs_t;

   logic          clkin = 1'b0;
   logic          resetn;
   logic [NP-1:0] pll_lock;
   logic [NP-1:0] pll_reset;
   logic          rst_out_n;
   logic          ready;
   logic          fault;
   logic          lock_lost;
   logic [NP-1:0] lost_mask;
   logic [1:0]    retry_count;

   pll_lock_supervisor #(
      .NUM_PLL(NP), .PLL_RST_CYCLES(PRC), .LOCK_FILTER(LF),
      .HOLD_CYCLES(HC), .LOCK_TIMEOUT(LT), .MAX_RETRIES(MR)
   ) dut (
      .clkin(clkin), .resetn(resetn), .pll_lock(pll_lock),
      .pll_reset(pll_reset), .rst_out_n(rst_out_n), .ready(ready),
      .fault(fault), .lock_lost(lock_lost), .lost_mask(lost_mask),
      .retry_count(retry_count)
   );

   always #5 clkin = ~clkin;

   outs_t         exp_q[$];
   int            tag_q[$];
   int            checks = 0;
   int            passes = 0;
   bit            done   = 1'b0;
   int            edge_no = 0;

   // Reference model: phase timeline with absolute entry times and a raw
   // lock history; all_lock at edge k is the raw AND sampled at edge k-2.
   logic [NP-1:0] raw_hist[$];
   int            n = -1;
   int            ph = PH_RST;
   int            ph_start = 0;
   int            retries = 0;
   logic [NP-1:0] lmask = '0;

   function automatic bit al(int k);
      if (k < 2) return 1'b0;
      return &raw_hist[k-2];
   endfunction

   function automatic bit window_ok(int t, int since);
      if (t - LF + 1 <= since) return 1'b0;
      for (int k = t - LF + 1; k <= t; k++)
         if (!al(k)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic attempt_failed();
      if (retries == MR) begin
         ph = PH_FAULT;
      end else begin
         retries++;
         ph       = PH_RST;
         ph_start = n;
      end
   endtask

   task automatic model_edge(input logic rn, input logic [NP-1:0] lk);
      outs_t e;
      bit    lost = 1'b0;
      if (!rn) begin
         n = -1; ph = PH_RST; ph_start = 0; retries = 0; lmask = '0;
         raw_hist.delete();
      end else begin
         n++;
         raw_hist.push_back(lk);
         case (ph)
            PH_RST:  if (n == ph_start + PRC) begin ph = PH_WAIT; ph_start = n; end
            PH_WAIT: begin
               if (window_ok(n, ph_start)) begin ph = PH_HOLD; ph_start = n; end
               else if (n == ph_start + LT) attempt_failed();
            end
            PH_HOLD: begin
               if (!al(n)) attempt_failed();
               else if (n == ph_start + HC) begin ph = PH_RUN; retries = 0; end
            end
            PH_RUN: begin
               if (!al(n)) begin
                  lost = 1'b1;
                  lmask = lmask | ~raw_hist[n-2];
                  ph = PH_RST; ph_start = n;
               end
            end
            default: ;
         endcase
      end
      e.pll_reset = (ph == PH_RST || ph == PH_FAULT) ? {NP{1'b1}} : '0;
      e.rst_out_n = (ph == PH_RUN);
      e.ready     = (ph == PH_RUN);
      e.fault     = (ph == PH_FAULT);
      e.lock_lost = lost;
      e.lost_mask = lmask;
      e.retry     = 2'(retries);
      exp_q.push_back(e);
      tag_q.push_back(edge_no);
   endtask

   task automatic step(input logic rn, input logic [NP-1:0] lk);
      resetn   = rn;
      pll_lock = lk;
      model_edge(rn, lk);
      edge_no++;
      @(posedge clkin);
      @(negedge clkin);
   endtask

   task automatic run(input int cycles, input logic [NP-1:0] lk);
      for (int i = 0; i < cycles; i++) step(1'b1, lk);
   endtask

   initial begin : monitor
      outs_t a, e;
      int    tag;
      forever begin
         @(posedge clkin);
         #1;
         if (!done) begin
            checks++;
            a = '{pll_reset, rst_out_n, ready, fault, lock_lost, lost_mask, retry_count};
            if (exp_q.size() == 0) begin
               $display("FAIL scoreboard_underflow: DUT output %b present, no expected entry", a);
            end else begin
               e   = exp_q.pop_front();
               tag = tag_q.pop_front();
               if (a === e) passes++;
               else $display("FAIL outputs@edge%0d: got pr=%b rn=%b rdy=%b flt=%b ll=%b lm=%b rc=%0d, expected pr=%b rn=%b rdy=%b flt=%b ll=%b lm=%b rc=%0d",
                             tag, a.pll_reset, a.rst_out_n, a.ready, a.fault, a.lock_lost, a.lost_mask, a.retry,
                             e.pll_reset, e.rst_out_n, e.ready, e.fault, e.lock_lost, e.lost_mask, e.retry);
            end
         end
      end
   end

   initial begin : stimulus
      int            left = 0;
      int            mode = 0;
      logic [NP-1:0] lk;
      logic          rn;

      // Locks high before release: straight through to RUN.
      for (int i = 0; i < 3; i++) step(1'b0, 2'b11);
      run(60, 2'b11);

      // Locks never assert: two retries then FAULT.
      step(1'b0, 2'b00);
      run(215, 2'b00);

      // Reset out of FAULT, reach RUN, single-cycle drop on PLL 1.
      step(1'b0, 2'b11);
      run(40, 2'b11);
      step(1'b1, 2'b01);
      run(50, 2'b11);

      // Periodic glitches keep the filter from ever completing.
      step(1'b0, 2'b11);
      for (int i = 0; i < 150; i++) step(1'b1, (i % 5 == 4) ? 2'b10 : 2'b11);

      // Lock drop inside HOLD, then recovery and a reset pulse in RUN.
      step(1'b0, 2'b11);
      run(18, 2'b11);
      run(3, 2'b00);
      run(60, 2'b11);
      step(1'b0, 2'b11);
      run(40, 2'b11);

      // Randomised segments of lock behaviour with sporadic resets.
      for (int i = 0; i < 1500; i++) begin
         if (left == 0) begin
            left = $urandom_range(1, 80);
            mode = $urandom_range(0, 4);
         end
         left--;
         case (mode)
            1:       lk = 2'b00;
            2:       lk = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            3:       lk = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            default: lk = 2'b11;
         endcase
         rn = ($urandom_range(0, 299) != 0);
         step(rn, lk);
      end

      done = 1'b1;
      checks++;
      if (exp_q.size() == 0) passes++;
      else $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
